mor1kx_ibus_wb_cappuccino: RTL and testbench

MOR1KX_IBUS_WB_CAPPUCCINO -- requirements
Module: mor1kx_ibus_wb_cappuccino

---
 rtl/mor1kx_ibus_wb_cappuccino.sv | 127 ++++++++++++
 tb/tb_mor1kx_ibus_wb_cappuccino.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_ibus_wb_cappuccino.sv
// Wishbone B3 classic instruction-bus bridge for the cappuccino fetch stage.
// Optional back-to-back fetch is enabled by defining MOR1KX_IBUS_B2B_EN.
module mor1kx_ibus_wb_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
  input  logic                            flush_i,
  output logic                            ack_o,
  output logic                            err_o,
  output logic [31:0]                     dat_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_adr_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [3:0]                      wb_sel_o,
  output logic [2:0]                      wb_cti_o,
  output logic [1:0]                      wb_bte_o,
  input  logic [31:0]                     wb_dat_i,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i,
  input  logic                            wb_rty_i
);

  typedef enum logic [1:0] {IDLE, READ, DISCARD, RETRY} state_t;

  // The counter never passes TIMEOUT_CYCLES-1: that value is the last open cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                            state_reg, state_next;
  logic [OPTION_OPERAND_WIDTH-1:0]   adr_reg, adr_next;
  logic [7:0]                        cnt_reg, cnt_next;
  logic [OPTION_OPERAND_WIDTH-1:0]   adr_aligned;
  logic                              term;
  logic                              timeout;
  logic                              unused_adr_bits;

  assign adr_aligned     = {adr_i[OPTION_OPERAND_WIDTH-1:2], 2'b00};
  assign unused_adr_bits = ^adr_i[1:0];
  assign term            = wb_ack_i | wb_err_i | wb_rty_i;
  assign timeout         = !term && (cnt_reg == CNT_LAST);

  assign wb_adr_o = adr_reg;
  assign wb_cyc_o = (state_reg == READ) || (state_reg == DISCARD);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hf;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign dat_o    = wb_dat_i;

  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    cnt_next   = cnt_reg;
    ack_o      = 1'b0;
    err_o      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_i && !flush_i) begin
          state_next = READ;
          adr_next   = adr_aligned;
          cnt_next   = 8'd0;
        end
      end
      READ: begin
        if (wb_ack_i) begin
          ack_o = !flush_i;
`ifdef MOR1KX_IBUS_B2B_EN
          if (req_i && !flush_i) begin
            adr_next = adr_aligned;
            cnt_next = 8'd0;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end else if (wb_err_i) begin
          err_o      = !flush_i;
          state_next = IDLE;
        end else if (wb_rty_i) begin
          // A retried access that is also being flushed is simply dropped.
          state_next = flush_i ? IDLE : RETRY;
        end else if (timeout) begin
          err_o      = !flush_i;
          state_next = IDLE;
        end else begin
          cnt_next = 8'(cnt_reg + 8'd1);
          if (flush_i)
            state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (term || timeout)
          state_next = IDLE;
        else
          cnt_next = 8'(cnt_reg + 8'd1);
      end
      RETRY: begin
        state_next = flush_i ? IDLE : READ;
        cnt_next   = 8'd0;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      ack_o = 1'b0;
      err_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      adr_reg   <= '0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mor1kx_ibus_wb_cappuccino.sv
// Bench for mor1kx_ibus_wb_cappuccino: directed scenarios then random traffic,
// every cycle compared against an access-level reference model.
module tb_mor1kx_ibus_wb_cappuccino;

  localparam int TO = 6;
`ifdef MOR1KX_IBUS_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req_i, flush_i;
  logic [31:0] adr_i, wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        ack_o, err_o;
  logic [31:0] dat_o, wb_adr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;

  int checks = 0;
  int errors = 0;

  // Reference model: one open bus access, whether it still belongs to fetch,
  // whether a retry gap is pending, its address and its age in cycles.
  bit          m_open, m_live, m_gap;
  logic [31:0] m_adr;
  int          m_age;

  logic        obs_cyc, obs_ack, obs_err;
  logic [31:0] obs_dat;

  mor1kx_ibus_wb_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .adr_i(adr_i), .flush_i(flush_i),
    .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic tick(input logic r, input logic q, input logic [31:0] a, input logic f,
                      input logic k, input logic e, input logic y, input logic [31:0] d);
    bit exp_ack, exp_err, live, term, aged;
    rst = r; req_i = q; adr_i = a; flush_i = f;
    wb_ack_i = k; wb_err_i = e; wb_rty_i = y; wb_dat_i = d;
    term    = k | e | y;
    live    = m_open && m_live && !r;
    aged    = (m_age + 1 >= TO);
    exp_ack = live && k && !f;
    exp_err = live && !f && !k && (e || (!y && aged));
    #4;
    obs_cyc = wb_cyc_o; obs_ack = ack_o; obs_err = err_o; obs_dat = dat_o;
    chk("cyc", {31'd0, wb_cyc_o}, {31'd0, m_open});
    chk("stb", {31'd0, wb_stb_o}, {31'd0, m_open});
    chk("adr", wb_adr_o, m_adr);
    chk("ack", {31'd0, ack_o}, {31'd0, exp_ack});
    chk("err", {31'd0, err_o}, {31'd0, exp_err});
    chk("dat", dat_o, d);
    chk("consts", {22'd0, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}, {22'd0, 1'b0, 4'hf, 3'b000, 2'b00});
    if (ack_o) $display("txn ack adr=%08h dat=%08h t=%0t", wb_adr_o, dat_o, $time);
    if (err_o) $display("txn err adr=%08h t=%0t", wb_adr_o, $time);
    @(posedge clk);
    if (r) begin
      m_open = 0; m_live = 0; m_gap = 0; m_adr = '0; m_age = 0;
    end else if (m_gap) begin
      m_gap = 0;
      if (!f) begin m_open = 1; m_live = 1; m_age = 0; end
    end else if (!m_open) begin
      if (q && !f) begin m_open = 1; m_live = 1; m_adr = {a[31:2], 2'b00}; m_age = 0; end
    end else if (term) begin
      if (B2B && live && k && !f && q) begin
        m_adr = {a[31:2], 2'b00}; m_age = 0;
      end else if (live && !k && !e && y && !f) begin
        m_open = 0; m_gap = 1;
      end else begin
        m_open = 0; m_live = 0;
      end
    end else if (aged) begin
      m_open = 0; m_live = 0;
    end else begin
      m_age++;
      if (f) m_live = 0;
    end
    #1;
  endtask

  task automatic idle_tick();
    tick(0, 0, 32'h0, 0, 0, 0, 0, $urandom);
  endtask

  initial begin
    int acks, errs, cycs, n;
    logic q, f, k, e, y, r;
    logic [31:0] a;
    rst = 1; req_i = 0; adr_i = 0; flush_i = 0;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 0;
    @(posedge clk); #1;
    m_open = 0; m_live = 0; m_gap = 0; m_adr = '0; m_age = 0;

    // Reset with slave noise: outputs must stay quiet.
    tick(1, 1, 32'h40, 0, 1, 1, 0, 32'h1);
    tick(1, 0, 32'h0, 0, 0, 0, 0, 32'h2);
    chk("rst_cyc", {31'd0, obs_cyc}, 32'd0);

    // Single fetch with two wait states.
    tick(0, 1, 32'h100, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("w2_cyc1", {31'd0, obs_cyc}, 32'd1);
    tick(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 0, 1, 0, 0, 32'h15000000);
    chk("w2_ack3", {31'd0, obs_ack}, 32'd1);
    chk("w2_dat3", obs_dat, 32'h15000000);
    idle_tick();
    chk("w2_cyc4", {31'd0, obs_cyc}, 32'd0);

    // Four sequential fetches against a zero-wait slave.
    acks = 0; n = 0;
    while (acks < 4 && n < 12) begin
      q = (acks < 3) || (acks == 3 && !m_open);
      a = 32'h100 + 32'(4 * (acks + (m_open ? 1 : 0)));
      tick(0, q, a, 0, m_open, 0, 0, 32'h1000 + 32'(acks));
      if (obs_ack) acks++;
      n++;
    end
    chk("seq_acks", 32'(acks), 32'd4);
    chk("seq_cycles", 32'(n), B2B ? 32'd5 : 32'd8);
    idle_tick();

    // Flush one cycle after cyc rises; slave acks three cycles later.
    acks = 0;
    tick(0, 1, 32'h180, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    if (obs_ack) acks++;
    tick(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("fl_held", {31'd0, obs_cyc}, 32'd1);
    tick(0, 0, 32'h0, 0, 1, 0, 0, 32'hdead);
    if (obs_ack) acks++;
    chk("fl_noack", 32'(acks), 32'd0);
    tick(0, 1, 32'h200, 0, 0, 0, 0, 32'h0);
    chk("fl_idle", {31'd0, obs_cyc}, 32'd0);
    tick(0, 0, 32'h0, 0, 1, 0, 0, 32'h2222);
    chk("fl_newack", {31'd0, obs_ack}, 32'd1);
    idle_tick();

    // Retry on the first beat, then ack.
    acks = 0;
    tick(0, 1, 32'h301, 0, 0, 0, 0, 32'h0);
    tick(0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
    if (obs_ack) acks++;
    tick(0, 0, 32'h0, 0, 1, 1, 0, 32'h0);
    chk("rty_gap", {31'd0, obs_cyc}, 32'd0);
    if (obs_ack) acks++;
    tick(0, 0, 32'h0, 0, 1, 0, 0, 32'h3333);
    if (obs_ack) acks++;
    chk("rty_acks", 32'(acks), 32'd1);
    idle_tick();

    // Silent slave: timeout error exactly once.
    errs = 0; cycs = 0;
    tick(0, 1, 32'h400, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      idle_tick();
      if (obs_err) errs++;
      if (obs_cyc) cycs++;
    end
    chk("to_errs", 32'(errs), 32'd1);
    chk("to_cycs", 32'(cycs), 32'(TO));

    // Reset in the middle of an access.
    tick(0, 1, 32'h500, 0, 0, 0, 0, 32'h0);
    idle_tick();
    tick(1, 1, 32'h500, 0, 1, 0, 0, 32'h5);
    chk("rst_mid_ack", {31'd0, obs_ack}, 32'd0);
    tick(0, 0, 32'h0, 0, 1, 1, 0, 32'h6);
    chk("rst_mid_cyc", {31'd0, obs_cyc}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int w;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 11) == 0);
      a = $urandom;
      w = $urandom_range(0, 15);
      k = (w <= 5) || w == 8 || w == 9;
      e = (w == 6) || w == 8 || w == 9;
      y = (w == 7) || w == 9;
      if (!m_open && $urandom_range(0, 1) == 0) begin k = 0; e = 0; y = 0; end
      tick(r, q, a, f, k, e, y, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
